conv_mac_scheduler: RTL and testbench

//  Time-multiplexed scheduler for the FSK demod matched-filter/energy path: one shared FP32

---
 rtl/fsk_conv_pkg.sv | 24 ++
 rtl/conv_mac_scheduler_if.sv | 36 +++
 rtl/fir_sample_ring.sv | 43 ++++
 rtl/conv_mac_scheduler.sv | 154 +++++++++++++++
 tb/tb_conv_mac_scheduler.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsk_conv_pkg.sv
// Shared types and constants for the FSK matched-filter/energy MAC scheduler.
package fsk_conv_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL    = 3'd1,
    ST_MWAIT  = 3'd2,
    ST_ADD    = 3'd3,
    ST_AWAIT  = 3'd4,
    ST_SQ     = 3'd5,
    ST_SQWAIT = 3'd6,
    ST_OUT    = 3'd7
  } state_e;

  function automatic int tap_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/conv_mac_scheduler_if.sv
// Sample, coefficient, shared-FP-unit and result signals of the MAC scheduler.
interface conv_mac_scheduler_if;
  import fsk_conv_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic [DATA_W-1:0] coef_data;
  logic              coef_err;
  logic              mul_issue;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_res;
  logic              add_issue;
  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              busy;

  modport master (
    output s_valid, s_data, coef_we, coef_addr, coef_data, mul_res, add_res,
    input  s_ready, coef_err, mul_issue, mul_a, mul_b, add_issue, add_a, add_b,
           result, result_valid, busy
  );

  modport slave (
    input  s_valid, s_data, coef_we, coef_addr, coef_data, mul_res, add_res,
    output s_ready, coef_err, mul_issue, mul_a, mul_b, add_issue, add_a, add_b,
           result, result_valid, busy
  );

endinterface

// File: rtl/fir_sample_ring.sv
// T-entry sample delay line; tap 0 reads the newest sample, tap k the one k samples older.
module fir_sample_ring
  import fsk_conv_pkg::*;
#(
  parameter  int N  = 9,
  localparam int TW = tap_w(N)
) (
  input  logic              in_clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [TW-1:0]     tap,
  output logic [DATA_W-1:0] rdata
);

  localparam int T = N + 1;

  logic [DATA_W-1:0] ring [T];
  logic [TW-1:0]     wp;
  logic [TW-1:0]     newest;
  int                rd_pos;

  always_ff @(posedge in_clk) begin
    if (reset) begin
      wp <= '0;
      for (int i = 0; i < T; i++) ring[i] <= FP_ZERO;
    end else if (we) begin
      ring[wp] <= wdata;
      wp       <= (wp == TW'(N)) ? '0 : wp + 1'b1;
    end
  end

  // wp points at the slot to be overwritten next, so the newest entry sits just behind it
  assign newest = (wp == '0) ? TW'(N) : wp - 1'b1;

  always_comb begin
    rd_pos = int'(newest) - int'(tap);
    if (rd_pos < 0) rd_pos = rd_pos + T;
  end

  assign rdata = ring[TW'(rd_pos)];

endmodule

// File: rtl/conv_mac_scheduler.sv
// Time-multiplexed MAC scheduler: sequences T multiply/accumulate steps and one squaring
// per accepted sample through a single shared FP32 multiplier and adder.
module conv_mac_scheduler
  import fsk_conv_pkg::*;
#(
  parameter int N       = 9,
  parameter int MUL_LAT = 6,
  parameter int ADD_LAT = 11
) (
  input logic                 in_clk,
  input logic                 reset,
  conv_mac_scheduler_if.slave bus
);

  localparam int T      = N + 1;
  localparam int TW     = tap_w(N);
  localparam int MAXLAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int LW     = $clog2(MAXLAT + 1);

  state_e            state;
  logic [TW-1:0]     k;
  logic [LW-1:0]     cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] result_r;
  logic              result_valid_r;
  logic              coef_err_r;
  logic [DATA_W-1:0] coef [T];
  logic [DATA_W-1:0] tap_data;
  logic              accept;
  logic              coef_ok;

  assign accept  = (state == ST_IDLE) && bus.s_valid;
  assign coef_ok = bus.coef_we && (state == ST_IDLE) && (int'(bus.coef_addr) <= N);

  fir_sample_ring #(.N(N)) u_ring (
    .in_clk (in_clk),
    .reset  (reset),
    .we     (accept),
    .wdata  (bus.s_data),
    .tap    (k),
    .rdata  (tap_data)
  );

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      k              <= '0;
      cnt            <= '0;
      acc            <= FP_ZERO;
      prod           <= FP_ZERO;
      result_r       <= FP_ZERO;
      result_valid_r <= 1'b0;
      coef_err_r     <= 1'b0;
      for (int i = 0; i < T; i++) coef[i] <= FP_ONE;
    end else begin
      result_valid_r <= 1'b0;
      coef_err_r     <= bus.coef_we && !coef_ok;
      // The coefficient lands before MUL of tap 0, so a same-cycle accept sees the new value
      if (coef_ok) coef[TW'(bus.coef_addr)] <= bus.coef_data;

      case (state)
        ST_IDLE: begin
          if (bus.s_valid) begin
            acc   <= FP_ZERO;
            k     <= '0;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          cnt   <= LW'(MUL_LAT - 1);
          state <= ST_MWAIT;
        end
        ST_MWAIT: begin
          if (cnt == '0) begin
            prod  <= bus.mul_res;
            state <= ST_ADD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ADD: begin
          cnt   <= LW'(ADD_LAT - 1);
          state <= ST_AWAIT;
        end
        ST_AWAIT: begin
          if (cnt == '0) begin
            acc <= bus.add_res;
            if (k == TW'(N)) begin
              state <= ST_SQ;
            end else begin
              k     <= k + 1'b1;
              state <= ST_MUL;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SQ: begin
          cnt   <= LW'(MUL_LAT - 1);
          state <= ST_SQWAIT;
        end
        ST_SQWAIT: begin
          if (cnt == '0) begin
            prod  <= bus.mul_res;
            state <= ST_OUT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_OUT: begin
          result_r       <= prod;
          result_valid_r <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mul_issue = 1'b0;
    bus.mul_a     = FP_ZERO;
    bus.mul_b     = FP_ZERO;
    bus.add_issue = 1'b0;
    bus.add_a     = FP_ZERO;
    bus.add_b     = FP_ZERO;
    case (state)
      ST_MUL: begin
        bus.mul_issue = 1'b1;
        bus.mul_a     = tap_data;
        bus.mul_b     = coef[k];
      end
      ST_ADD: begin
        bus.add_issue = 1'b1;
        bus.add_a     = acc;
        bus.add_b     = prod;
      end
      ST_SQ: begin
        bus.mul_issue = 1'b1;
        bus.mul_a     = acc;
        bus.mul_b     = acc;
      end
      default: ;
    endcase
  end

  assign bus.s_ready      = (state == ST_IDLE);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.result       = result_r;
  assign bus.result_valid = result_valid_r;
  assign bus.coef_err     = coef_err_r;

endmodule

// File: tb/tb_conv_mac_scheduler.sv
// Bench for conv_mac_scheduler: behavioural fixed-latency FP32 units plus a direct
// convolution/energy reference model.
module tb_conv_mac_scheduler;
  import fsk_conv_pkg::*;

  localparam int N       = 9;
  localparam int T       = N + 1;
  localparam int MUL_LAT = 6;
  localparam int ADD_LAT = 11;
  localparam int LATENCY = T * (MUL_LAT + ADD_LAT + 2) + MUL_LAT + 2;

  logic in_clk = 1'b0;
  logic reset  = 1'b1;
  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_mis  = 0;
  int   last_acc = 0;

  conv_mac_scheduler_if bus();

  conv_mac_scheduler #(.N(N), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) dut (
    .in_clk (in_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) edge_n <= edge_n + 1;

  // FP32 <-> real helpers (normal numbers and zero only; stimulus stays small integers)
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'h0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] i2f(input int v);
    return r2f(real'(v));
  endfunction

  // Shared FP units: result is on the bus LAT cycles after the issue cycle
  logic [31:0] mul_pipe [MUL_LAT];
  logic [31:0] add_pipe [ADD_LAT];

  always @(posedge in_clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= 32'h0;
      for (int i = 0; i < ADD_LAT; i++) add_pipe[i] <= 32'h0;
    end else begin
      mul_pipe[0] <= bus.mul_issue ? r2f(f2r(bus.mul_a) * f2r(bus.mul_b)) : 32'h0;
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
      add_pipe[0] <= bus.add_issue ? r2f(f2r(bus.add_a) + f2r(bus.add_b)) : 32'h0;
      for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end

  assign bus.mul_res = mul_pipe[MUL_LAT-1];
  assign bus.add_res = add_pipe[ADD_LAT-1];

  // Reference model: coefficient table and sample history, hist_m[0] is the newest sample
  real coef_m [T];
  real hist_m [T];

  task automatic model_clear();
    for (int i = 0; i < T; i++) begin
      coef_m[i] = 1.0;
      hist_m[i] = 0.0;
    end
  endtask

  task automatic model_accept(input logic [31:0] x, output logic [31:0] e);
    real s;
    for (int i = T - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
    hist_m[0] = f2r(x);
    s = 0.0;
    for (int i = 0; i < T; i++) s += coef_m[i] * hist_m[i];
    e = r2f(s * s);
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    int waited = 0;
    while (!bus.s_ready && waited < LATENCY + 50) begin
      @(negedge in_clk);
      waited++;
    end
    ok = bus.s_ready;
    if (!ok) check_val("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.s_valid   = 1'b0;
    bus.coef_we   = 1'b0;
    @(negedge in_clk);
    @(negedge in_clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic coef_write(input logic [3:0] a, input logic [31:0] d);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = a;
      bus.coef_data = d;
      if (int'(a) <= N) coef_m[a] = f2r(d);
      @(negedge in_clk);
      check_val("coef_err_idle_wr", {31'h0, bus.coef_err}, {31'h0, int'(a) > N});
      bus.coef_we = 1'b0;
    end
  endtask

  // One sample; optional same-cycle coefficient write and a rejected write while busy
  task automatic run_one(input logic [31:0] x, input bit hold, input bit gap_chk,
                         input bit cw, input logic [3:0] caddr, input logic [31:0] cdata,
                         input int busy_wr_at);
    logic [31:0] e;
    int          acc_edge;
    int          mi;
    bit          seen;
    bit          ok;
    wait_ready(ok);
    if (ok) begin
      if (cw) begin
        bus.coef_we   = 1'b1;
        bus.coef_addr = caddr;
        bus.coef_data = cdata;
        if (int'(caddr) <= N) coef_m[caddr] = f2r(cdata);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = x;
      model_accept(x, e);
      acc_edge = edge_n + 1;
      if (gap_chk) check_val("accept_gap", acc_edge - last_acc, 32'd199);
      last_acc = acc_edge;
      @(negedge in_clk);
      if (cw) check_val("coef_err_accept", {31'h0, bus.coef_err}, {31'h0, int'(caddr) > N});
      bus.coef_we = 1'b0;
      if (!hold) bus.s_valid = 1'b0;
      mi   = 0;
      seen = 1'b0;
      for (int i = 0; i < LATENCY + 50; i++) begin
        if (bus.result_valid) begin
          seen = 1'b1;
          break;
        end
        if (bus.mul_issue) mi++;
        if (busy_wr_at >= 0 && i == busy_wr_at) begin
          bus.coef_we   = 1'b1;
          bus.coef_addr = 4'd1;
          bus.coef_data = 32'h4100_0000;
        end
        if (busy_wr_at >= 0 && i == busy_wr_at + 1) begin
          check_val("coef_err_busy", {31'h0, bus.coef_err}, 32'd1);
          bus.coef_we = 1'b0;
        end
        @(negedge in_clk);
      end
      if (!seen) begin
        check_val("result_timeout", 32'd0, 32'd1);
      end else begin
        check_val("latency", edge_n - acc_edge, LATENCY);
        check_val("result", bus.result, e);
        check_val("mul_issues", mi, T + 1);
      end
    end
  endtask

  initial begin
    int  rv_cnt;
    bit  ok;
    bus.s_valid   = 1'b0;
    bus.s_data    = 32'h0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = 4'h0;
    bus.coef_data = 32'h0;

    do_reset();
    check_val("rst_result", bus.result, 32'h0);
    check_val("rst_result_valid", {31'h0, bus.result_valid}, 32'd0);
    check_val("rst_s_ready", {31'h0, bus.s_ready}, 32'd1);
    check_val("rst_busy", {31'h0, bus.busy}, 32'd0);
    check_val("rst_mul_issue", {31'h0, bus.mul_issue}, 32'd0);
    check_val("rst_add_issue", {31'h0, bus.add_issue}, 32'd0);
    check_val("rst_coef_err", {31'h0, bus.coef_err}, 32'd0);
    check_val("rst_mul_a", bus.mul_a, 32'h0);

    // Ramp of ones fills the delay line, then wraps
    for (int i = 0; i < 11; i++) begin
      run_one(FP_ONE, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, -1);
      check_val($sformatf("ramp_%0d", i), bus.result, i2f((i < T) ? (i + 1) * (i + 1) : T * T));
      if (i == 0)  check_val("first_one", bus.result, 32'h3F80_0000);
      if (i == 9)  check_val("tenth_hundred", bus.result, 32'h42C8_0000);
      if (i == 10) check_val("wrap_hundred", bus.result, 32'h42C8_0000);
    end

    do_reset();
    coef_write(4'd0, 32'h4000_0000);
    run_one(FP_ONE, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, -1);
    check_val("coef0_two", bus.result, 32'h4080_0000);

    coef_write(4'd10, 32'h4040_0000);
    run_one(i2f(2), 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 20);
    check_val("busy_wr_ignored", bus.result, i2f(25));
    run_one(i2f(3), 1'b0, 1'b0, 1'b1, 4'd2, i2f(-3), -1);
    check_val("same_cycle_wr", bus.result, i2f(25));

    // Abort a computation 50 cycles in
    wait_ready(ok);
    bus.s_valid = 1'b1;
    bus.s_data  = i2f(5);
    @(negedge in_clk);
    bus.s_valid = 1'b0;
    repeat (49) @(negedge in_clk);
    reset = 1'b1;
    @(negedge in_clk);
    reset = 1'b0;
    model_clear();
    check_val("abort_s_ready", {31'h0, bus.s_ready}, 32'd1);
    check_val("abort_result", bus.result, 32'h0);
    check_val("abort_busy", {31'h0, bus.busy}, 32'd0);
    rv_cnt = 0;
    for (int i = 0; i < LATENCY + 20; i++) begin
      if (bus.result_valid) rv_cnt++;
      @(negedge in_clk);
    end
    check_val("abort_no_valid", rv_cnt, 32'd0);
    run_one(FP_ONE, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, -1);
    check_val("post_abort_one", bus.result, 32'h3F80_0000);

    // Random coefficients, then s_valid held high across a random sample stream
    for (int i = 0; i < 4; i++)
      coef_write(4'($urandom_range(N, 0)), i2f(int'($urandom_range(8, 0)) - 4));
    for (int i = 0; i < 8; i++) begin
      run_one(i2f(int'($urandom_range(16, 0)) - 8), 1'b1, i > 0, i == 3,
              4'($urandom_range(N, 0)), i2f(int'($urandom_range(8, 0)) - 4), -1);
    end
    bus.s_valid = 1'b0;
    repeat (3) @(negedge in_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
